wb_regfile_stage: RTL

//  Writeback stage plus architectural register file, directly downstream of the C->W

---
 rtl/wb_regfile_stage.sv | 135 +++++++++++++
 1 files changed

// File: rtl/wb_regfile_stage.sv
// wb_regfile_stage: writeback select, architectural register file with two
// combinational read ports, writeback forwarding outputs, a saturating count
// of committed writes and a sticky illegal-destination flag.
// Optional feature: define WB_BYPASS_EN for same-cycle write-through reads.
module wb_regfile_stage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_ADDR_W = 7,
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] W_dataD,
    input  logic [DATA_WIDTH-1:0] W_w,
    input  logic [REG_ADDR_W-1:0] W_regDst,
    input  logic                  W_MuxD,
    input  logic                  W_RF_wrd,
    input  logic [REG_ADDR_W-1:0] D_addrA,
    input  logic [REG_ADDR_W-1:0] D_addrB,
    output logic [DATA_WIDTH-1:0] D_dataA,
    output logic [DATA_WIDTH-1:0] D_dataB,
    output logic                  wb_fwd_valid,
    output logic [REG_ADDR_W-1:0] wb_fwd_reg,
    output logic [DATA_WIDTH-1:0] wb_fwd_data,
    output logic [CNT_WIDTH-1:0]  wb_count,
    output logic                  wb_illegal
);

    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  illegal_q, illegal_d;

    logic [DATA_WIDTH-1:0] wdata;
    logic                  dst_in_range;
    logic                  dst_nonzero;
    logic                  commit;
    logic [IDX_W-1:0]      widx;

    logic                  a_in_range, b_in_range;
    logic [IDX_W-1:0]      aidx, bidx;

    // Address range checks are done at 32 bits so NUM_REGS may equal 2**REG_ADDR_W.
    function automatic logic addr_ok(input logic [REG_ADDR_W-1:0] a);
        return 32'(a) < NUM_REGS;
    endfunction

    // Writeback select and commit qualification.
    always_comb begin
        wdata        = W_MuxD ? W_dataD : W_w;
        dst_in_range = addr_ok(W_regDst);
        dst_nonzero  = (W_regDst != '0);
        commit       = W_RF_wrd && dst_nonzero && dst_in_range;
        widx         = W_regDst[IDX_W-1:0];
    end

    // Next-state for the saturating commit counter and sticky illegal flag.
    always_comb begin
        count_d   = count_q;
        illegal_d = illegal_q;
        if (commit && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
        if (W_RF_wrd && !dst_in_range) begin
            illegal_d = 1'b1;
        end
    end

    // Register file storage; entry 0 is never written and always reads as zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit) begin
            regs_q[widx] <= wdata;
        end
    end

    // Status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            illegal_q <= illegal_d;
        end
    end

    // Read address decode for both ports.
    always_comb begin
        a_in_range = addr_ok(D_addrA) && (D_addrA != '0);
        b_in_range = addr_ok(D_addrB) && (D_addrB != '0);
        aidx       = D_addrA[IDX_W-1:0];
        bidx       = D_addrB[IDX_W-1:0];
    end

    // Read port A: zero for index 0, out-of-range or during reset; optional bypass.
    always_comb begin
        D_dataA = '0;
        if (!reset && a_in_range) begin
            D_dataA = regs_q[aidx];
`ifdef WB_BYPASS_EN
            if (commit && (D_addrA == W_regDst)) begin
                D_dataA = wdata;
            end
`endif
        end
    end

    // Read port B: same behaviour as port A.
    always_comb begin
        D_dataB = '0;
        if (!reset && b_in_range) begin
            D_dataB = regs_q[bidx];
`ifdef WB_BYPASS_EN
            if (commit && (D_addrB == W_regDst)) begin
                D_dataB = wdata;
            end
`endif
        end
    end

    // Forwarding outputs are unqualified; consumers gate with wb_fwd_valid.
    always_comb begin
        wb_fwd_valid = commit;
        wb_fwd_reg   = W_regDst;
        wb_fwd_data  = wdata;
        wb_count     = count_q;
        wb_illegal   = illegal_q;
    end

endmodule
